// File: rtl/posit_pkg.sv
// ============================================================================
// Module   : posit_pkg
// Purpose  : Shared posit widths, the NaR pattern and the unpacked-operand
//            struct used by the decoder, multiplier and encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package posit_pkg;

  // Default system format.
  localparam int POSIT_N  = 16;
  localparam int POSIT_ES = 3;

  // Signed scale width: regime k needs $clog2(n)+1 bits, then ES bits of e.
  function automatic int scale_width(input int n, input int es);
    return $clog2(n) + es + 1;
  endfunction

  // Mantissa width including the hidden bit.
  function automatic int mant_width(input int n, input int es);
    return n - es - 2;
  endfunction

  localparam int POSIT_SCALE_W = scale_width(POSIT_N, POSIT_ES);
  localparam int POSIT_MANT_W  = mant_width(POSIT_N, POSIT_ES);

  // NaR is the sign bit alone.
  localparam logic [POSIT_N-1:0] NAR_PATTERN = {1'b1, {(POSIT_N-1){1'b0}}};

  typedef struct packed {
    logic                            sign;
    logic                            zero;
    logic                            nar;
    logic signed [POSIT_SCALE_W-1:0] scale;
    logic [POSIT_MANT_W-1:0]         mant;
  } posit_unpacked_t;

endpackage

`default_nettype wire

// File: rtl/posit_lzc.sv
// ============================================================================
// Module   : posit_lzc
// Purpose  : Counts the run of bits identical to the MSB, starting at the MSB.
//            The run may extend all the way to bit 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module posit_lzc #(
  parameter int W  = 15,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] run
);

  logic stop;

  // Walk down from the MSB until the first bit that differs.
  always_comb begin
    run  = CW'(1);
    stop = 1'b0;
    for (int i = W - 2; i >= 0; i--) begin
      if (!stop) begin
        if (bits[i] == bits[W-1]) begin
          run = run + CW'(1);
        end else begin
          stop = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/posit_decode_pipe.sv
// ============================================================================
// Module   : posit_decode_pipe
// Purpose  : Two-stage posit field extractor with valid/ready handshake.
//            Stage 1: specials, absolute value, regime run and k.
//            Stage 2: regime strip, exponent/fraction split, scale and mant.
//            Optional macro POSIT_DECODE_STATS_EN adds a saturating NaR
//            output-transfer counter (nar_count) with a clear (stats_clr).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module posit_decode_pipe
  import posit_pkg::*;
#(
  parameter int N       = 16,
  parameter int ES      = 3,
  parameter int SCALE_W = scale_width(N, ES),
  parameter int MANT_W  = mant_width(N, ES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_posit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic               out_zero,
  output logic               out_nar,
  output logic [SCALE_W-1:0] out_scale,
  output logic [MANT_W-1:0]  out_mant
`ifdef POSIT_DECODE_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [15:0]        nar_count
`endif
);

  localparam int RUN_W  = $clog2(N);    // run length 1..N-1
  localparam int K_W    = RUN_W + 1;    // signed regime value
  localparam int TAIL_W = N - 3;        // bits below the two always-consumed ones
  localparam int FRAC_W = MANT_W - 1;

  localparam logic [N-1:0]          NAR_WORD = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-2:0]          ABS_ZERO = '0;
  localparam logic signed [K_W-1:0] K_ONE    = 1;
  localparam logic signed [K_W-1:0] K_ZERO   = 0;
  localparam logic [RUN_W-1:0]      RUN_ONE  = 1;

  logic w_adv1;
  logic w_adv2;

  // Stage 1 combinational
  logic [N-2:0]          w_abs;
  logic [RUN_W-1:0]      w_run;
  logic signed [K_W-1:0] w_run_s;
  logic signed [K_W-1:0] w_k;
  logic                  w_zero;
  logic                  w_nar;

  // Stage 1 registers
  logic                  r_s1_valid;
  logic                  r_s1_sign;
  logic                  r_s1_zero;
  logic                  r_s1_nar;
  logic signed [K_W-1:0] r_s1_k;
  logic [RUN_W-1:0]      r_s1_run;
  logic [TAIL_W-1:0]     r_s1_tail;

  // Stage 2 combinational
  logic [RUN_W-1:0]      w_shift;
  logic [TAIL_W-1:0]     w_rem;
  logic [ES-1:0]         w_e;
  logic [FRAC_W-1:0]     w_frac;
  logic [SCALE_W-1:0]    w_scale;
  logic                  w_special;

  // Handshake: an empty or draining stage always accepts.
  always_comb begin
    w_adv2 = !out_valid || out_ready;
    w_adv1 = !r_s1_valid || w_adv2;
  end

  assign in_ready = w_adv1;

  // Stage 1 datapath: specials, two's-complement magnitude and regime value.
  always_comb begin
    w_zero  = (in_posit == '0);
    w_nar   = (in_posit == NAR_WORD);
    w_abs   = in_posit[N-1] ? (ABS_ZERO - in_posit[N-2:0]) : in_posit[N-2:0];
    w_run_s = $signed({1'b0, w_run});
    w_k     = w_abs[N-2] ? (w_run_s - K_ONE) : (K_ZERO - w_run_s);
  end

  posit_lzc #(
    .W  (N - 1),
    .CW (RUN_W)
  ) u_lzc (
    .bits (w_abs),
    .run  (w_run)
  );

  // Stage 1 register: holds while stage 2 is stalled and this stage is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_nar   <= 1'b0;
      r_s1_k     <= '0;
      r_s1_run   <= '0;
      r_s1_tail  <= '0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign <= in_posit[N-1];
        r_s1_zero <= w_zero;
        r_s1_nar  <= w_nar;
        r_s1_k    <= w_k;
        r_s1_run  <= w_run;
        r_s1_tail <= w_abs[TAIL_W-1:0];
      end
    end
  end

  // Stage 2 datapath. The top two magnitude bits always belong to the regime
  // or its terminator, so stripping m+1 bits equals shifting the tail by m-1.
  // A run reaching bit 0 shifts everything out, leaving e and fraction zero.
  always_comb begin
    w_shift   = r_s1_run - RUN_ONE;
    w_rem     = r_s1_tail << w_shift;
    w_e       = w_rem[TAIL_W-1 -: ES];
    w_frac    = w_rem[FRAC_W-1:0];
    // k <<< ES plus an unsigned e below 2^ES is exactly the concatenation.
    w_scale   = {r_s1_k, w_e};
    w_special = r_s1_zero || r_s1_nar;
  end

  // Output register: frozen while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_zero  <= 1'b0;
      out_nar   <= 1'b0;
      out_scale <= '0;
      out_mant  <= '0;
    end else if (w_adv2) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_sign  <= r_s1_sign;
        out_zero  <= r_s1_zero;
        out_nar   <= r_s1_nar;
        out_scale <= w_special ? '0 : w_scale;
        out_mant  <= w_special ? '0 : {1'b1, w_frac};
      end
    end
  end

`ifdef POSIT_DECODE_STATS_EN
  logic [15:0] r_nar_count;

  // Saturating count of NaR operands handed to the consumer; clear wins.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      r_nar_count <= '0;
    end else if (out_valid && out_ready && out_nar && (r_nar_count != 16'hFFFF)) begin
      r_nar_count <= r_nar_count + 16'd1;
    end
  end

  assign nar_count = r_nar_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_posit_decode_pipe.sv
// ============================================================================
// Module   : tb_posit_decode_pipe
// Purpose  : Self-checking bench for posit_decode_pipe (N=16, ES=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_posit_decode_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_posit;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic        out_zero;
  logic        out_nar;
  logic [7:0]  out_scale;
  logic [10:0] out_mant;
`ifdef POSIT_DECODE_STATS_EN
  logic        stats_clr;
  logic [15:0] nar_count;
`endif

  posit_decode_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_posit  (in_posit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_zero  (out_zero),
    .out_nar   (out_nar),
    .out_scale (out_scale),
    .out_mant  (out_mant)
`ifdef POSIT_DECODE_STATS_EN
    ,
    .stats_clr (stats_clr),
    .nar_count (nar_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic sign;
    logic zero;
    logic nar;
    int   scale;
    int   mant;
  } exp_t;

  int   checks    = 0;
  int   failures  = 0;
  int   pop_count = 0;
  logic low_seen  = 1'b0;
  exp_t q[$];

  logic        prev_stall = 1'b0;
  logic [21:0] prev_bus   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, $signed(act), $signed(exp));
    end
  endtask

  // Reference decode: read the posit bit by bit as sign, regime run,
  // terminator, ES exponent bits and fraction, padding with zeros past bit 0.
  function automatic exp_t model(input logic [15:0] p);
    exp_t       r;
    logic [15:0] a;
    logic       rb;
    int         i, m, k, e, f;
    r.sign  = p[15];
    r.zero  = (p == 16'h0000);
    r.nar   = (p == 16'h8000);
    r.scale = 0;
    r.mant  = 0;
    if (r.zero || r.nar) return r;
    a  = p[15] ? (16'h0000 - p) : p;
    rb = a[14];
    m  = 0;
    i  = 14;
    while (i >= 0 && a[i] == rb) begin
      m++;
      i--;
    end
    k = rb ? (m - 1) : -m;
    i--;
    e = 0;
    repeat (3) begin
      e = e * 2 + ((i >= 0) ? int'(a[i]) : 0);
      i--;
    end
    f = 0;
    repeat (10) begin
      f = f * 2 + ((i >= 0) ? int'(a[i]) : 0);
      i--;
    end
    r.scale = k * 8 + e;
    r.mant  = 1024 + f;
    return r;
  endfunction

  // Compare process: handshake, stall stability and scoreboard ordering.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready", 32'(in_ready), (q.size() == 2 && !out_ready) ? 32'd0 : 32'd1);
      if (!in_ready) low_seen = 1'b1;
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'({out_sign, out_zero, out_nar, out_scale, out_mant}), 32'(prev_bus));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: actual=mant %0h required=none", out_mant);
        end else begin
          e = q.pop_front();
          pop_count++;
          check("sb_sign",  32'(out_sign), 32'(e.sign));
          check("sb_zero",  32'(out_zero), 32'(e.zero));
          check("sb_nar",   32'(out_nar),  32'(e.nar));
          check("sb_scale", 32'($signed(out_scale)), e.scale);
          check("sb_mant",  32'(out_mant), e.mant);
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_posit));
      prev_stall = out_valid && !out_ready;
      prev_bus   = {out_sign, out_zero, out_nar, out_scale, out_mant};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated word with literal expectations and exact 2-cycle latency.
  task automatic send_vec(input logic [15:0] v, input logic s, input logic z,
                          input logic n, input int sc, input int mt);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_posit  = v;
    tick();
    in_valid  = 1'b0;
    in_posit  = 16'hxxxx;
    @(negedge clk);
    check("lat_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lit_sign",  32'(out_sign), 32'(s));
    check("lit_zero",  32'(out_zero), 32'(z));
    check("lit_nar",   32'(out_nar),  32'(n));
    check("lit_scale", 32'($signed(out_scale)), sc);
    check("lit_mant",  32'(out_mant), mt);
    tick();
  endtask

  logic [15:0] words [8];
  logic [3:0]  pat;

  initial begin
    int idx;
    int cyc;
    int start;
    logic took;

    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int cyc;
    int start;
    logic took;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_posit  = 16'h0000;
    out_ready = 1'b0;
`ifdef POSIT_DECODE_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_scale",     32'(out_scale), 32'd0);
    check("rst_mant",      32'(out_mant),  32'd0);
    check("rst_flags",     32'({out_sign, out_zero, out_nar}), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Directed vectors with hand-derived fields.
    send_vec(16'h4000, 1'b0, 1'b0, 1'b0,    0, 11'h400);
    send_vec(16'h4200, 1'b0, 1'b0, 1'b0,    0, 11'h600);
    send_vec(16'hC000, 1'b1, 1'b0, 1'b0,    0, 11'h400);
    send_vec(16'h0000, 1'b0, 1'b1, 1'b0,    0, 0);
    send_vec(16'h8000, 1'b1, 1'b0, 1'b1,    0, 0);
    send_vec(16'h7FFF, 1'b0, 1'b0, 1'b0,  112, 11'h400);
    send_vec(16'h0001, 1'b0, 1'b0, 1'b0, -112, 11'h400);
    send_vec(16'h2A80, 1'b0, 1'b0, 1'b0,   -6, 11'h680);
    send_vec(16'hD580, 1'b1, 1'b0, 1'b0,   -6, 11'h680);

    // Back-to-back stream under a 1,0,0,1 consumer pattern.
    words = '{16'h4000, 16'hC000, 16'h2A80, 16'h8000,
              16'h7FFF, 16'h0001, 16'hD580, 16'h4200};
    pat      = 4'b1001;
    low_seen = 1'b0;
    start    = pop_count;
    idx      = 0;
    cyc      = 0;
    while (idx < 8 && cyc < 200) begin
      out_ready = pat[cyc % 4];
      in_valid  = 1'b1;
      in_posit  = words[idx];
      #3;
      took = in_ready;
      tick();
      if (took) idx++;
      cyc++;
    end
    in_valid  = 1'b0;
    in_posit  = 16'hxxxx;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && q.size() != 0; c++) tick();
    tick();
    check("stream_sent",  32'(idx), 32'd8);
    check("stream_drain", 32'(q.size()), 32'd0);
    check("stream_count", 32'(pop_count - start), 32'd8);
    check("stream_backpressure", 32'(low_seen), 32'd1);

    // Reset with two words in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_posit  = 16'h4000;
    tick();
    in_posit  = 16'h4200;
    tick();
    in_valid  = 1'b0;
    @(negedge clk);
    check("flush_full", 32'({out_valid, in_ready}), 32'b10);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready",  32'(in_ready),  32'd1);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("flush_no_emit", 32'(out_valid), 32'd0);
    end
    tick();

`ifdef POSIT_DECODE_STATS_EN
    check("stats_start", 32'(nar_count), 32'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_posit  = 16'h8000;
    tick();
    in_posit  = 16'h4000;
    tick();
    in_posit  = 16'h8000;
    tick();
    tick();
    in_valid  = 1'b0;
    repeat (4) tick();
    check("stats_count", 32'(nar_count), 32'd3);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    @(negedge clk);
    check("stats_clear", 32'(nar_count), 32'd0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
